// File: rtl/types_pkg.sv
// Shared channel-level type definitions.
package types_pkg;

   // Channel operating state, driven by the channel controller.
   typedef enum logic [3:0] {
      STATE_INIT    = 4'd0,
      STATE_IDLE    = 4'd1,
      STATE_ARM     = 4'd2,
      STATE_ACQ     = 4'd3,
      STATE_READOUT = 4'd4
   } state_t;

endpackage

// File: rtl/ch_readout_shifter.sv
// Channel readout serializer: on entry into STATE_READOUT, captures
// {trig_cnt, cnt_data} and shifts it out MSB first, one bit per shift_en strobe.
// Optional feature macro READOUT_PARITY_EN appends an even-parity bit after bit 0.
module ch_readout_shifter
   import types_pkg::*;
#(
   parameter int unsigned CNT_W   = 12,
   parameter int unsigned NUM_CNT = 4,
   parameter int unsigned TRIG_W  = 8
) (
   input  logic                     clk,
   input  logic                     rstb,
   input  state_t                   state,
   input  logic [NUM_CNT*CNT_W-1:0] cnt_data,
   input  logic [TRIG_W-1:0]        trig_cnt,
   input  logic                     shift_en,
   output logic                     sout,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned FRAME_W = TRIG_W + NUM_CNT * CNT_W;
`ifdef READOUT_PARITY_EN
   localparam int unsigned FrameLen = FRAME_W + 1;
`else
   localparam int unsigned FrameLen = FRAME_W;
`endif
   localparam int unsigned CntBits = $clog2(FRAME_W + 1);
   localparam logic [CntBits-1:0] LastIdx = CntBits'(FrameLen - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } fsm_e;

   fsm_e                  fsm_q, fsm_d;
   state_t                prev_state_q;
   // Holds the bits still to be presented; the current bit lives in sout_q.
   logic [FrameLen-2:0]   sr_q, sr_d;
   logic [CntBits-1:0]    cnt_q, cnt_d;
   logic                  sout_q, sout_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [FrameLen-1:0]   frame;
   logic                  in_ro;
   logic                  entry;

   assign in_ro = (state == STATE_READOUT);
   assign entry = in_ro && (prev_state_q != STATE_READOUT);

   // Assemble the frame from the live inputs; only used on the load cycle.
   always_comb begin
`ifdef READOUT_PARITY_EN
      frame = {trig_cnt, cnt_data, ^{trig_cnt, cnt_data}};
`else
      frame = {trig_cnt, cnt_data};
`endif
   end

   // Next-state and output logic for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      fsm_d  = fsm_q;
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      sout_d = sout_q;
      busy_d = busy_q;
      done_d = done_q;
      unique case (fsm_q)
         StIdle: begin
            sout_d = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b0;
            if (entry) begin
               fsm_d  = StShift;
               sr_d   = frame[FrameLen-2:0];
               sout_d = frame[FrameLen-1];
               cnt_d  = '0;
               busy_d = 1'b1;
            end
         end
         StShift: begin
            if (!in_ro) begin
               // Abort: partial frame is discarded.
               fsm_d  = StIdle;
               sr_d   = '0;
               cnt_d  = '0;
               sout_d = 1'b0;
               busy_d = 1'b0;
               done_d = 1'b0;
            end else if (shift_en) begin
               if (cnt_q == LastIdx) begin
                  fsm_d  = StDone;
                  sr_d   = '0;
                  sout_d = 1'b0;
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  sout_d = sr_q[FrameLen-2];
                  sr_d   = {sr_q[FrameLen-3:0], 1'b0};
                  cnt_d  = cnt_q + CntBits'(1);
               end
            end
         end
         StDone: begin
            // Staying in readout holds DONE; a new frame needs a fresh entry edge.
            if (!in_ro) begin
               fsm_d  = StIdle;
               done_d = 1'b0;
            end
         end
         default: begin
            fsm_d = StIdle;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         fsm_q        <= StIdle;
         prev_state_q <= STATE_INIT;
         sr_q         <= '0;
         cnt_q        <= '0;
         sout_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         prev_state_q <= state;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         sout_q       <= sout_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign sout = sout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_ch_readout_shifter.sv
// Directed self-checking bench for ch_readout_shifter at default parameters.
module tb_ch_readout_shifter;
   import types_pkg::*;

   localparam int FRAME_W = 56;
`ifdef READOUT_PARITY_EN
   localparam int LEN = FRAME_W + 1;
`else
   localparam int LEN = FRAME_W;
`endif

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   state_t      st = STATE_IDLE;
   logic [47:0] cnt_data = '0;
   logic [7:0]  trig_cnt = '0;
   logic        shift_en = 1'b0;
   logic        sout, busy, done;

   int total = 0;
   int bad = 0;

   ch_readout_shifter dut (
      .clk      (clk),
      .rstb     (rstb),
      .state    (st),
      .cnt_data (cnt_data),
      .trig_cnt (trig_cnt),
      .shift_en (shift_en),
      .sout     (sout),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic s, input logic b, input logic d);
      chk({tag, ".sout"}, {63'd0, sout}, {63'd0, s});
      chk({tag, ".busy"}, {63'd0, busy}, {63'd0, b});
      chk({tag, ".done"}, {63'd0, done}, {63'd0, d});
   endtask

   // Expected serial frame, including the parity bit when that build is selected.
   function automatic logic [63:0] exp_frame(input logic [55:0] f);
`ifdef READOUT_PARITY_EN
      return {7'd0, f, ^f};
`else
      return {8'd0, f};
`endif
   endfunction

   // Reads the frame starting at the bit currently on sout, then consumes the last bit.
   task automatic collect(input string tag, input logic [55:0] f);
      logic [63:0] acc;
      acc = {63'd0, sout};
      for (int i = 1; i < LEN; i++) begin
         shift_en = 1'b1;
         step();
         shift_en = 1'b0;
         if (i % 7 == 0) step();  // idle gap: sout must hold
         acc = {acc[62:0], sout};
      end
      chk({tag, ".frame"}, acc, exp_frame(f));
      chk({tag, ".busy_last"}, {63'd0, busy & ~done}, 64'd1);
      shift_en = 1'b1;
      step();
      shift_en = 1'b0;
      chk_out({tag, ".end"}, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // Reset state
      #2;
      chk_out("reset", 1'b0, 1'b0, 1'b0);
      #10 rstb = 1'b1;
      step();
      step();
      chk_out("idle", 1'b0, 1'b0, 1'b0);

      // Basic frame
      trig_cnt = 8'hA5;
      cnt_data = 48'h123_456_789_ABC;
      st = STATE_READOUT;
      step();
      chk_out("basic.load", 1'b1, 1'b1, 1'b0);
      collect("basic", 56'hA5123456789ABC);
      step();
      step();
      chk_out("basic.noreload", 1'b0, 1'b0, 1'b1);

      // Leave readout from DONE, then abort mid-frame after 20 pulses
      st = STATE_IDLE;
      step();
      chk_out("done.exit", 1'b0, 1'b0, 1'b0);
      st = STATE_READOUT;
      step();
      for (int i = 0; i < 20; i++) begin
         shift_en = 1'b1;
         step();
      end
      shift_en = 1'b0;
      chk({"abort.mid_busy"}, {63'd0, busy}, 64'd1);
      st = STATE_ACQ;
      step();
      chk_out("abort", 1'b0, 1'b0, 1'b0);
      trig_cnt = 8'h3C;
      cnt_data = 48'hFED_CBA_987_654;
      st = STATE_READOUT;
      step();
      chk_out("reentry.load", 1'b0, 1'b1, 1'b0);
      collect("reentry", 56'h3CFEDCBA987654);

      // Stray strobes in IDLE and on the load cycle; inputs change after load
      st = STATE_IDLE;
      shift_en = 1'b1;
      step();
      step();
      step();
      chk_out("stray.idle", 1'b0, 1'b0, 1'b0);
      trig_cnt = 8'h81;
      cnt_data = 48'h000_FFF_0F0_00F;
      st = STATE_READOUT;
      step();
      shift_en = 1'b0;
      chk_out("stray.load", 1'b1, 1'b1, 1'b0);
      cnt_data = '1;
      trig_cnt = 8'h00;
      collect("stray", 56'h81000FFF0F000F);

      // Async reset mid-frame at pulse 30, state held in readout
      st = STATE_IDLE;
      trig_cnt = 8'h5A;
      cnt_data = 48'h0AA_555_123_321;
      step();
      st = STATE_READOUT;
      step();
      for (int i = 0; i < 30; i++) begin
         shift_en = 1'b1;
         step();
      end
      shift_en = 1'b0;
      chk({"rst.mid_busy"}, {63'd0, busy}, 64'd1);
      #2 rstb = 1'b0;
      #1;
      chk_out("rst.async", 1'b0, 1'b0, 1'b0);
      step();
      chk_out("rst.held", 1'b0, 1'b0, 1'b0);
      #2 rstb = 1'b1;
      step();
      chk_out("rst.reload", 1'b0, 1'b1, 1'b0);
      collect("rst", 56'h5A0AA555123321);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
